run_monitor: RTL and testbench

- Synthesizable run-completion monitor for the ad1xx CPU family; sits beside the core and snoops its retire and data-memory-write buses.
- Replaces bench-side polling for "instruction stopped changing, then read RAM". Detects a jump-to-self halt after a configurable number of identical retires, enforces a runtime timeout, and captures a window of result words in RAM.
- Counts cycles and retired instructions; usable in simulation benches and in FPGA self-test builds.

---
 rtl/run_monitor_pkg.sv | 31 +++
 rtl/run_monitor_if.sv | 16 +
 rtl/run_monitor_watch.sv | 39 +++
 rtl/run_monitor.sv | 137 +++++++++++++
 tb/tb_run_monitor.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared types for the run-completion monitor.
//   state_t      : monitor FSM states
//   widx_t       : watch-window decode result (hit flag + word index)
//   watch_decode : maps a byte address onto the watch window
package run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] idx;
  } widx_t;

  // The offset wraps at addr_w bits, the same way the address bus would.
  // A hit needs a word-aligned address and an in-window word index.
  function automatic widx_t watch_decode(logic [63:0] addr, logic [63:0] base,
                                         int unsigned addr_w, int unsigned num);
    logic [63:0] off;
    widx_t       r;
    off   = (addr - base) & (~64'd0 >> (64 - addr_w));
    r.hit = (addr[1:0] == 2'b00) && ((off >> 2) < 64'(num));
    r.idx = 32'(off >> 2);
    return r;
  endfunction

endpackage

// File: rtl/run_monitor_if.sv
// run_monitor_if: core-side retire and data-memory write buses snooped by the
// monitor. master = core (drives), slave = monitor (observes).
interface run_monitor_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              retire_valid;
  logic [ADDR_W-1:0] retire_pc;
  logic [XLEN-1:0]   retire_inst;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;

  modport master (output retire_valid, retire_pc, retire_inst, mem_we, mem_addr, mem_wdata);
  modport slave  (input  retire_valid, retire_pc, retire_inst, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/run_monitor_watch.sv
// run_monitor_watch: NUM_WATCH-word capture register file.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero all words (wins over a write)
//   en         : capture enabled (monitor is running)
//   we/addr/wdata : snooped data-memory write
//   data       : captured words, word i at [i]
module run_monitor_watch
  import run_monitor_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          ADDR_W     = 32,
  parameter int          NUM_WATCH  = 4,
  parameter logic [63:0] WATCH_BASE = 64'd0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           en,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [XLEN-1:0]                wdata,
  output logic [NUM_WATCH-1:0][XLEN-1:0] data
);

  widx_t dec;
  assign dec = watch_decode(64'(addr), WATCH_BASE, ADDR_W, NUM_WATCH);

  for (genvar i = 0; i < NUM_WATCH; i++) begin : g_word
    logic sel;
    assign sel = en && we && dec.hit && (dec.idx == 32'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   data[i] <= '0;
      else if (clr) data[i] <= '0;
      else if (sel) data[i] <= wdata;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: run-completion monitor for the ad1xx core.
//   clk, rst_n     : clock, async active-low reset
//   start          : pulse; clears state and enters RUN
//   timeout_limit  : max RUN cycles, 0 = no timeout
//   bus            : snooped retire / data-memory write buses (slave)
//   busy           : in RUN
//   halted         : self-loop halt confirmed (sticky)
//   timed_out      : timeout hit (sticky)
//   halt_pc        : pc of the self-loop
//   cycle_count    : RUN cycles (saturating)
//   retire_count   : retires in RUN (saturating)
//   watch_data     : captured result words, word i at [i*XLEN +: XLEN]
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          ADDR_W       = 32,
  parameter int          STABLE_COUNT = 4,
  parameter int          MATCH_INST   = 1,
  parameter int          NUM_WATCH    = 4,
  parameter logic [63:0] WATCH_BASE   = 64'd0,
  parameter int          CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          timeout_limit,
  run_monitor_if.slave              bus,
  output logic                      busy,
  output logic                      halted,
  output logic                      timed_out,
  output logic [ADDR_W-1:0]         halt_pc,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          retire_count,
  output logic [NUM_WATCH*XLEN-1:0] watch_data
);

  localparam int RW = $clog2(STABLE_COUNT + 1);

  state_t            state;
  logic              last_valid;
  logic [ADDR_W-1:0] last_pc;
  logic [XLEN-1:0]   last_inst;
  logic [RW-1:0]     repeat_cnt;

  logic              in_run;
  logic              same;
  logic [RW-1:0]     rep_inc;
  logic              halt_hit;
  logic              tmo_hit;
  logic [CNT_W-1:0]  tmo_at;

  assign in_run   = (state == RUN);
  assign same     = last_valid && (bus.retire_pc == last_pc) &&
                    ((MATCH_INST == 0) || (bus.retire_inst == last_inst));
  assign rep_inc  = repeat_cnt + 1'b1;
  assign halt_hit = in_run && bus.retire_valid && same && (rep_inc == RW'(STABLE_COUNT));
  // Compare before the increment so cycle_count lands on timeout_limit.
  assign tmo_at   = timeout_limit - 1'b1;
  assign tmo_hit  = in_run && (timeout_limit != '0) && (cycle_count == tmo_at);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      halted       <= 1'b0;
      timed_out    <= 1'b0;
      halt_pc      <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      last_valid   <= 1'b0;
      last_pc      <= '0;
      last_inst    <= '0;
      repeat_cnt   <= '0;
    end else if (start) begin
      // Restart from any state; a retire on this cycle is not counted.
      state        <= RUN;
      busy         <= 1'b1;
      halted       <= 1'b0;
      timed_out    <= 1'b0;
      halt_pc      <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      last_valid   <= 1'b0;
      last_pc      <= '0;
      last_inst    <= '0;
      repeat_cnt   <= '0;
    end else if (in_run) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;

      if (bus.retire_valid) begin
        if (retire_count != '1) retire_count <= retire_count + 1'b1;
        if (!same) begin
          last_valid <= 1'b1;
          last_pc    <= bus.retire_pc;
          last_inst  <= bus.retire_inst;
          repeat_cnt <= '0;
        end else begin
          repeat_cnt <= rep_inc;
        end
      end

      // Halt has priority over a timeout on the same edge.
      if (halt_hit) begin
        state   <= HALTED;
        busy    <= 1'b0;
        halted  <= 1'b1;
        halt_pc <= last_pc;
      end else if (tmo_hit) begin
        state     <= TIMEOUT;
        busy      <= 1'b0;
        timed_out <= 1'b1;
      end
    end
  end

  logic [NUM_WATCH-1:0][XLEN-1:0] wdata_q;

  run_monitor_watch #(
    .XLEN       (XLEN),
    .ADDR_W     (ADDR_W),
    .NUM_WATCH  (NUM_WATCH),
    .WATCH_BASE (WATCH_BASE)
  ) u_watch (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (in_run),
    .we    (bus.mem_we),
    .addr  (bus.mem_addr),
    .wdata (bus.mem_wdata),
    .data  (wdata_q)
  );

  assign watch_data = wdata_q;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: drives two monitors (MATCH_INST=1 and MATCH_INST=0) with the
// same stimulus and checks every cycle against a behavioural model, plus
// directed checks of the headline scenarios.
module tb_run_monitor;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int SC   = 4;
  localparam int NW   = 4;
  localparam int CW   = 32;
  localparam longint CMAX = 64'hFFFF_FFFF;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_TMO = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] tl = '0;

  logic [1:0]              busy_o, halted_o, tmo_o;
  logic [1:0][AW-1:0]      hpc_o;
  logic [1:0][CW-1:0]      cyc_o, ret_o;
  logic [1:0][NW*XLEN-1:0] wat_o;

  always #5 clk = ~clk;

  run_monitor_if #(.XLEN(XLEN), .ADDR_W(AW)) bus0 ();
  run_monitor_if #(.XLEN(XLEN), .ADDR_W(AW)) bus1 ();

  run_monitor #(.XLEN(XLEN), .ADDR_W(AW), .STABLE_COUNT(SC), .MATCH_INST(1),
                .NUM_WATCH(NW), .WATCH_BASE(64'd0), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .timeout_limit(tl), .bus(bus0),
    .busy(busy_o[0]), .halted(halted_o[0]), .timed_out(tmo_o[0]), .halt_pc(hpc_o[0]),
    .cycle_count(cyc_o[0]), .retire_count(ret_o[0]), .watch_data(wat_o[0]));

  run_monitor #(.XLEN(XLEN), .ADDR_W(AW), .STABLE_COUNT(SC), .MATCH_INST(0),
                .NUM_WATCH(NW), .WATCH_BASE(64'd0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .timeout_limit(tl), .bus(bus1),
    .busy(busy_o[1]), .halted(halted_o[1]), .timed_out(tmo_o[1]), .halt_pc(hpc_o[1]),
    .cycle_count(cyc_o[1]), .retire_count(ret_o[1]), .watch_data(wat_o[1]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: index 0 matches pc+inst, index 1 matches pc only.
  int          m_st   [2];
  longint      m_cyc  [2];
  longint      m_ret  [2];
  bit          m_lv   [2];
  logic [31:0] m_lpc  [2];
  logic [31:0] m_linst[2];
  int          m_len  [2];
  bit          m_hlt  [2];
  bit          m_tmo  [2];
  logic [31:0] m_hpc  [2];
  logic [31:0] m_w    [2][NW];

  task automatic mdl_clear(int k, int st);
    m_st[k] = st; m_cyc[k] = 0; m_ret[k] = 0; m_lv[k] = 0;
    m_lpc[k] = 0; m_linst[k] = 0; m_len[k] = 0;
    m_hlt[k] = 0; m_tmo[k] = 0; m_hpc[k] = 0;
    for (int i = 0; i < NW; i++) m_w[k][i] = 0;
  endtask

  task automatic mdl_step(int k, bit s, bit rv, logic [31:0] pc, logic [31:0] inst,
                          bit we, logic [31:0] a, logic [31:0] wd);
    bit hit;
    if (s) begin mdl_clear(k, M_RUN); return; end
    if (m_st[k] != M_RUN) return;
    if (we && a[1:0] == 2'b00 && a < 4 * NW) m_w[k][a >> 2] = wd;
    m_cyc[k] = (m_cyc[k] + 1 > CMAX) ? CMAX : m_cyc[k] + 1;
    hit = 0;
    if (rv) begin
      m_ret[k] = (m_ret[k] + 1 > CMAX) ? CMAX : m_ret[k] + 1;
      // Length of the run of identical consecutive retires.
      if (m_lv[k] && pc == m_lpc[k] && (k == 1 || inst == m_linst[k])) m_len[k]++;
      else begin m_len[k] = 1; m_lv[k] = 1; m_lpc[k] = pc; m_linst[k] = inst; end
      if (m_len[k] == SC + 1) hit = 1;
    end
    if (hit) begin
      m_st[k] = M_HALT; m_hlt[k] = 1; m_hpc[k] = pc;
    end else if (tl != 0 && m_cyc[k] == longint'(tl)) begin
      m_st[k] = M_TMO; m_tmo[k] = 1;
    end
  endtask

  task automatic cmp(int k);
    logic [NW*XLEN-1:0] w;
    for (int i = 0; i < NW; i++) w[i*XLEN +: XLEN] = m_w[k][i];
    chk($sformatf("busy%0d", k),   busy_o[k],   m_st[k] == M_RUN);
    chk($sformatf("halted%0d", k), halted_o[k], m_hlt[k]);
    chk($sformatf("tmo%0d", k),    tmo_o[k],    m_tmo[k]);
    chk($sformatf("hpc%0d", k),    hpc_o[k],    m_hpc[k]);
    chk($sformatf("cyc%0d", k),    cyc_o[k],    m_cyc[k][31:0]);
    chk($sformatf("ret%0d", k),    ret_o[k],    m_ret[k][31:0]);
    chk($sformatf("watch%0d", k),  wat_o[k],    w);
  endtask

  task automatic drive(bit rv, logic [31:0] pc, logic [31:0] inst,
                       bit we, logic [31:0] a, logic [31:0] wd);
    bus0.retire_valid = rv; bus0.retire_pc = pc; bus0.retire_inst = inst;
    bus0.mem_we = we; bus0.mem_addr = a; bus0.mem_wdata = wd;
    bus1.retire_valid = rv; bus1.retire_pc = pc; bus1.retire_inst = inst;
    bus1.mem_we = we; bus1.mem_addr = a; bus1.mem_wdata = wd;
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(bit s, bit rv, logic [31:0] pc, logic [31:0] inst,
                      bit we, logic [31:0] a, logic [31:0] wd);
    start = s;
    drive(rv, pc, inst, we, a, wd);
    for (int k = 0; k < 2; k++) mdl_step(k, s, rv, pc, inst, we, a, wd);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) cmp(k);
    start = 1'b0;
  endtask

  task automatic idle_cyc();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam logic [31:0] JSELF = 32'h0000_006F;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) mdl_clear(k, M_IDLE);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) cmp(k);
    rst_n = 1'b1;
    idle_cyc();
    // Retire/write outside RUN is ignored.
    step(0, 1, 32'h0C, JSELF, 1, 32'h0, 32'hDEAD);

    // Basic halt with watch capture.
    tl = 0;
    step(1, 1, 32'h0C, JSELF, 0, 0, 0);
    step(0, 1, 32'h00, NOP, 1, 32'h00, 32'h37);
    step(0, 1, 32'h04, NOP, 1, 32'h04, 32'h05);
    step(0, 1, 32'h08, NOP, 1, 32'h10, 32'h99);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h0C, JSELF, 0, 0, 0);
    chk("pre_halt", halted_o[0], 1'b0);
    step(0, 1, 32'h0C, JSELF, 0, 0, 0);
    chk("halt", halted_o[0], 1'b1);
    chk("halt_pc", hpc_o[0], 32'h0C);
    chk("halt_busy", busy_o[0], 1'b0);
    chk("halt_ret", ret_o[0], 32'd8);
    chk("watch_win", wat_o[0], {32'h0, 32'h0, 32'h5, 32'h37});
    idle_cyc();
    chk("halt_hold", cyc_o[0], 32'd8);

    // Timeout with distinct pcs.
    tl = 20;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 1, 32'h200 + 32'(4 * i), NOP, 0, 0, 0);
    chk("tmo", tmo_o[0], 1'b1);
    chk("tmo_cyc", cyc_o[0], 32'd20);
    chk("tmo_halt", halted_o[0], 1'b0);

    // Timeout disabled.
    tl = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) step(0, 1, 32'h1000 + 32'(4 * i), NOP, 0, 0, 0);
    chk("notmo", tmo_o[0], 1'b0);
    chk("notmo_busy", busy_o[0], 1'b1);
    chk("notmo_cyc", cyc_o[0], 32'd1000);

    // Same pc, alternating inst: only the pc-only monitor halts.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 32'h40, (i % 2) ? JSELF : NOP, 0, 0, 0);
    chk("alt_m1", halted_o[0], 1'b0);
    chk("alt_m0", halted_o[1], 1'b1);
    chk("alt_m0_pc", hpc_o[1], 32'h40);

    // Halt and timeout on the same edge.
    tl = 5;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h300, JSELF, 0, 0, 0);
    chk("tie_halt", halted_o[0], 1'b1);
    chk("tie_tmo", tmo_o[0], 1'b0);
    chk("tie_cyc", cyc_o[0], 32'd5);

    // Async reset mid-RUN, then a fresh halt, then restart from HALTED.
    tl = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h80, JSELF, 1, 32'h8, 32'h77);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) mdl_clear(k, M_IDLE);
    for (int k = 0; k < 2; k++) cmp(k);
    chk("rst_watch", wat_o[0], 128'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h80, JSELF, 0, 0, 0);
    chk("fresh_nohalt", halted_o[0], 1'b0);
    step(0, 1, 32'h80, JSELF, 0, 0, 0);
    chk("fresh_halt", halted_o[0], 1'b1);
    step(1, 1, 32'h80, JSELF, 0, 0, 0);
    chk("restart_busy", busy_o[0], 1'b1);
    chk("restart_halt", halted_o[0], 1'b0);
    chk("restart_ret", ret_o[0], 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc, inst;
      int r;
      if (i % 150 == 0) tl = ($urandom_range(0, 2) == 0) ? 0 : 32'($urandom_range(8, 80));
      r    = $urandom_range(0, 9);
      pc   = (r < 6) ? 32'h100 : (r < 8) ? 32'h104 : 32'h108;
      inst = ($urandom_range(0, 3) == 0) ? NOP : JSELF;
      step((i % 40 == 0) || ($urandom_range(0, 99) == 0),
           $urandom_range(0, 3) != 0, pc, inst,
           $urandom_range(0, 1) == 1, 32'($urandom_range(0, 31)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
